cache_tag_ctrl: RTL

Tag-side controller for the 8-way set-associative cache. It splits each request address into tag, index and byte select, holds the tag/valid/dirty arrays and per-set true-LRU state, and runs hit/miss lookup. On a miss it selects a victim and sequences a dirty-victim writeback and a line fill over a memory request handshake. The block sits between the CPU-side request port and the memory interface. The data array is outside this block and is steered by `resp_way`.

---
 rtl/cache_tag_ctrl.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: tag/valid/dirty/LRU storage and miss sequencing for an
// A_SIZE-way set-associative cache. The data array lives outside and is
// steered by resp_way.
module cache_tag_ctrl #(
   parameter int unsigned I_SIZE = 64,
   parameter int unsigned D_SIZE = 6,
   parameter int unsigned C_SIZE = 14,
   parameter int unsigned A_SIZE = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [I_SIZE-1:0]         req_addr,
   output logic                      resp_valid,
   output logic                      resp_hit,
   output logic [$clog2(A_SIZE)-1:0] resp_way,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_we,
   output logic [I_SIZE-1:0]         mem_req_addr,
   input  logic                      mem_done,
   output logic [31:0]               hit_count,
   output logic [31:0]               miss_count
);

   localparam int unsigned WAY_W  = $clog2(A_SIZE);
   localparam int unsigned IDX_W  = C_SIZE - WAY_W - D_SIZE;
   localparam int unsigned TAG_W  = I_SIZE - IDX_W - D_SIZE;
   localparam int unsigned N_SETS = 1 << IDX_W;
   localparam int unsigned CNT_W  = 32;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOOKUP    = 3'd1,
      WB_REQ    = 3'd2,
      WB_WAIT   = 3'd3,
      FILL_REQ  = 3'd4,
      FILL_WAIT = 3'd5,
      RESP      = 3'd6
   } state_e;

   // control and latched request
   state_e                  state_q, state_d;
   logic                    we_q, we_d;
   logic [TAG_W-1:0]        tag_q, tag_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [WAY_W-1:0]        victim_q, victim_d;

   // registered outputs
   logic                    req_ready_q, req_ready_d;
   logic                    resp_valid_q, resp_valid_d;
   logic                    resp_hit_q, resp_hit_d;
   logic [WAY_W-1:0]        resp_way_q, resp_way_d;
   logic                    mem_req_valid_q, mem_req_valid_d;
   logic                    mem_req_we_q, mem_req_we_d;
   logic [I_SIZE-1:0]       mem_req_addr_q, mem_req_addr_d;
   logic [CNT_W-1:0]        hit_count_q, hit_count_d;
   logic [CNT_W-1:0]        miss_count_q, miss_count_d;

   // tag-side arrays
   logic [TAG_W-1:0]        tag_arr_q [N_SETS][A_SIZE];
   logic [A_SIZE-1:0]       valid_q   [N_SETS];
   logic [A_SIZE-1:0]       dirty_q   [N_SETS];
   logic [WAY_W-1:0]        age_q     [N_SETS][A_SIZE];

   // lookup results and array update strobes
   logic                    hit_c;
   logic [WAY_W-1:0]        hit_way_c;
   logic [WAY_W-1:0]        victim_c;
   logic                    inv_found_c;
   logic [WAY_W-1:0]        inv_way_c;
   logic [WAY_W-1:0]        lru_way_c;
   logic                    lru_upd_c;
   logic [WAY_W-1:0]        upd_way_c;
   logic                    set_dirty_c;
   logic                    fill_c;
   logic                    hit_inc_c;
   logic                    miss_inc_c;
   logic [WAY_W-1:0]        age_new_c [A_SIZE];

   // byte-select bits play no part in tag-side decisions
   logic                    unused_byte_sel;
   assign unused_byte_sel = ^req_addr[D_SIZE-1:0];

   // Tag compare across the set, plus victim choice (first invalid, else oldest)
   always_comb begin
      hit_c       = 1'b0;
      hit_way_c   = '0;
      inv_found_c = 1'b0;
      inv_way_c   = '0;
      lru_way_c   = '0;
      for (int w = 0; w < int'(A_SIZE); w++) begin
         if (valid_q[idx_q][w] && (tag_arr_q[idx_q][w] == tag_q)) begin
            hit_c     = 1'b1;
            hit_way_c = WAY_W'(w);
         end
         if (!valid_q[idx_q][w] && !inv_found_c) begin
            inv_found_c = 1'b1;
            inv_way_c   = WAY_W'(w);
         end
         if (age_q[idx_q][w] == WAY_W'(A_SIZE - 1)) begin
            lru_way_c = WAY_W'(w);
         end
      end
      victim_c = inv_found_c ? inv_way_c : lru_way_c;
   end

   // New ages for the set when upd_way_c becomes most recently used
   always_comb begin
      for (int w = 0; w < int'(A_SIZE); w++) begin
         if (WAY_W'(w) == upd_way_c) begin
            age_new_c[w] = '0;
         end else if (age_q[idx_q][w] < age_q[idx_q][upd_way_c]) begin
            age_new_c[w] = age_q[idx_q][w] + WAY_W'(1);
         end else begin
            age_new_c[w] = age_q[idx_q][w];
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d        = state_q;
      we_d           = we_q;
      tag_d          = tag_q;
      idx_d          = idx_q;
      victim_d       = victim_q;
      resp_hit_d     = resp_hit_q;
      resp_way_d     = resp_way_q;
      mem_req_we_d   = mem_req_we_q;
      mem_req_addr_d = mem_req_addr_q;
      lru_upd_c      = 1'b0;
      upd_way_c      = hit_way_c;
      set_dirty_c    = 1'b0;
      fill_c         = 1'b0;
      hit_inc_c      = 1'b0;
      miss_inc_c     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               we_d    = req_we;
               tag_d   = req_addr[I_SIZE-1 -: TAG_W];
               idx_d   = req_addr[D_SIZE +: IDX_W];
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit_c) begin
               lru_upd_c   = 1'b1;
               set_dirty_c = we_q;
               hit_inc_c   = 1'b1;
               resp_hit_d  = 1'b1;
               resp_way_d  = hit_way_c;
               state_d     = RESP;
            end else begin
               miss_inc_c = 1'b1;
               victim_d   = victim_c;
               if (valid_q[idx_q][victim_c] && dirty_q[idx_q][victim_c]) begin
                  mem_req_we_d   = 1'b1;
                  mem_req_addr_d = {tag_arr_q[idx_q][victim_c], idx_q, {D_SIZE{1'b0}}};
                  state_d        = WB_REQ;
               end else begin
                  mem_req_we_d   = 1'b0;
                  mem_req_addr_d = {tag_q, idx_q, {D_SIZE{1'b0}}};
                  state_d        = FILL_REQ;
               end
            end
         end
         WB_REQ: begin
            if (mem_req_ready) state_d = WB_WAIT;
         end
         WB_WAIT: begin
            if (mem_done) begin
               mem_req_we_d   = 1'b0;
               mem_req_addr_d = {tag_q, idx_q, {D_SIZE{1'b0}}};
               state_d        = FILL_REQ;
            end
         end
         FILL_REQ: begin
            if (mem_req_ready) state_d = FILL_WAIT;
         end
         FILL_WAIT: begin
            if (mem_done) begin
               fill_c     = 1'b1;
               lru_upd_c  = 1'b1;
               upd_way_c  = victim_q;
               resp_hit_d = 1'b0;
               resp_way_d = victim_q;
               state_d    = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_ready_d     = (state_d == IDLE);
      resp_valid_d    = (state_q == RESP);
      mem_req_valid_d = (state_d == WB_REQ) || (state_d == FILL_REQ);
      hit_count_d     = (hit_inc_c && (hit_count_q != '1)) ? hit_count_q + CNT_W'(1) : hit_count_q;
      miss_count_d    = (miss_inc_c && (miss_count_q != '1)) ? miss_count_q + CNT_W'(1) : miss_count_q;
   end

   // Control state, latched request and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         we_q            <= 1'b0;
         tag_q           <= '0;
         idx_q           <= '0;
         victim_q        <= '0;
         req_ready_q     <= 1'b1;
         resp_valid_q    <= 1'b0;
         resp_hit_q      <= 1'b0;
         resp_way_q      <= '0;
         mem_req_valid_q <= 1'b0;
         mem_req_we_q    <= 1'b0;
         mem_req_addr_q  <= '0;
         hit_count_q     <= '0;
         miss_count_q    <= '0;
      end else begin
         state_q         <= state_d;
         we_q            <= we_d;
         tag_q           <= tag_d;
         idx_q           <= idx_d;
         victim_q        <= victim_d;
         req_ready_q     <= req_ready_d;
         resp_valid_q    <= resp_valid_d;
         resp_hit_q      <= resp_hit_d;
         resp_way_q      <= resp_way_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_req_we_q    <= mem_req_we_d;
         mem_req_addr_q  <= mem_req_addr_d;
         hit_count_q     <= hit_count_d;
         miss_count_q    <= miss_count_d;
      end
   end

   // Tag, valid, dirty and age arrays
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < int'(N_SETS); s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < int'(A_SIZE); w++) begin
               tag_arr_q[s][w] <= '0;
               age_q[s][w]     <= WAY_W'(w);
            end
         end
      end else begin
         if (fill_c) begin
            tag_arr_q[idx_q][victim_q] <= tag_q;
            valid_q[idx_q][victim_q]   <= 1'b1;
            dirty_q[idx_q][victim_q]   <= we_q;
         end
         if (set_dirty_c) begin
            dirty_q[idx_q][hit_way_c] <= 1'b1;
         end
         if (lru_upd_c) begin
            for (int w = 0; w < int'(A_SIZE); w++) begin
               age_q[idx_q][w] <= age_new_c[w];
            end
         end
      end
   end

   assign req_ready     = req_ready_q;
   assign resp_valid    = resp_valid_q;
   assign resp_hit      = resp_hit_q;
   assign resp_way      = resp_way_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_we    = mem_req_we_q;
   assign mem_req_addr  = mem_req_addr_q;
   assign hit_count     = hit_count_q;
   assign miss_count    = miss_count_q;

endmodule
